// File: rtl/alu_isa_pkg.sv
// Shared ISA definitions for the ALU issue controller: instruction field
// positions, opcode/funct encodings, FSM state and immediate-extension kinds.
package alu_isa_pkg;

  localparam int unsigned XLen   = 32;
  localparam int unsigned RegCnt = 32;
  localparam int unsigned RegAw  = 5;

  // Instruction field positions
  localparam int unsigned OpcMsb   = 31;
  localparam int unsigned OpcLsb   = 26;
  localparam int unsigned RsMsb    = 25;
  localparam int unsigned RsLsb    = 21;
  localparam int unsigned RtMsb    = 20;
  localparam int unsigned RtLsb    = 16;
  localparam int unsigned RdMsb    = 15;
  localparam int unsigned RdLsb    = 11;
  localparam int unsigned ImmMsb   = 15;
  localparam int unsigned ImmLsb   = 0;
  localparam int unsigned FunctMsb = 5;
  localparam int unsigned FunctLsb = 0;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSubi  = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b010000;
  localparam logic [5:0] OpOri   = 6'b010001;
  localparam logic [5:0] OpXori  = 6'b010010;
  localparam logic [5:0] OpSlli  = 6'b011000;
  localparam logic [5:0] OpSrli  = 6'b011001;
  localparam logic [5:0] OpSrai  = 6'b011010;
  localparam logic [5:0] OpLui   = 6'b110000;

  // R-type funct codes
  localparam logic [5:0] FnAdd     = 6'b001000;
  localparam logic [5:0] FnSub     = 6'b001001;
  localparam logic [5:0] FnInc     = 6'b001010;
  localparam logic [5:0] FnDec     = 6'b001011;
  localparam logic [5:0] FnSlt     = 6'b001100;
  localparam logic [5:0] FnSgt     = 6'b001101;
  localparam logic [5:0] FnLogicLo = 6'b010000;
  localparam logic [5:0] FnLogicHi = 6'b010100;
  localparam logic [5:0] FnSll     = 6'b011001;
  localparam logic [5:0] FnSrl     = 6'b011010;
  localparam logic [5:0] FnSra     = 6'b011011;
  localparam logic [5:0] FnHam     = 6'b101000;
  localparam logic [5:0] FnMove    = 6'b110000;
  localparam logic [5:0] FnCmov    = 6'b110001;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StExec,
    StWb
  } state_e;

  typedef enum logic [1:0] {
    ExtSext,
    ExtZext,
    ExtLui
  } ext_kind_e;

  typedef enum logic {
    DestRd,
    DestRt
  } dest_sel_e;

  // LUI presents the raw immediate; the ALU itself moves it to the upper half.
  function automatic logic [XLen-1:0] extend_imm(input ext_kind_e kind, input logic [15:0] imm);
    logic [XLen-1:0] ext;
    unique case (kind)
      ExtSext: ext = {{16{imm[15]}}, imm};
      ExtZext: ext = {16'h0000, imm};
      ExtLui:  ext = {16'h0000, imm};
      default: ext = {16'h0000, imm};
    endcase
    return ext;
  endfunction

  // Add/sub class: the only operations whose overflow flag is meaningful.
  function automatic logic is_arith(input logic rtype, input logic [5:0] opcode,
                                    input logic [5:0] funct);
    logic arith;
    if (rtype) begin
      arith = funct inside {[FnAdd:FnDec]};
    end else begin
      arith = opcode inside {OpAddi, OpSubi};
    end
    return arith;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode: legality of opcode/funct, R/I format, immediate
// extension kind and destination-field select.
module alu_issue_decode
  import alu_isa_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       legal,
  output logic       is_rtype,
  output ext_kind_e  ext_kind,
  output dest_sel_e  dest_sel
);

  // Classify the instruction; anything not listed is illegal.
  always_comb begin
    legal    = 1'b0;
    is_rtype = (opcode == OpRtype);
    ext_kind = ExtZext;
    dest_sel = DestRt;
    if (is_rtype) begin
      dest_sel = DestRd;
      legal    = funct inside {[FnAdd:FnSgt], [FnLogicLo:FnLogicHi], [FnSll:FnSra],
                               FnHam, FnMove, FnCmov};
    end else begin
      unique case (opcode)
        OpAddi, OpSubi: begin
          legal    = 1'b1;
          ext_kind = ExtSext;
        end
        OpAndi, OpOri, OpXori, OpSlli, OpSrli, OpSrai: begin
          legal    = 1'b1;
          ext_kind = ExtZext;
        end
        OpLui: begin
          legal    = 1'b1;
          ext_kind = ExtLui;
        end
        default: begin
          legal = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the combinational 32-bit ALU.
// Four-state FSM (IDLE, DECODE, EXEC, WB), one instruction per four cycles,
// with an internal 32x32 register file (r0 hard-wired to zero).
// Optional feature: define ALU_ISSUE_OVF_TRAP_EN to suppress the register
// write of an overflowing add/sub-class op and raise a sticky ovf_trap.
module alu_issue_ctrl
  import alu_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_funct,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        done,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        zero_flag,
  output logic        illegal,
  output logic        ovf_trap
);

  state_e            state_q;
  logic [31:0]       instr_q;
  logic [XLen-1:0]   regs_q [RegCnt];
  logic [RegAw-1:0]  dest_q;
  logic              legal_q;
  logic              arith_q;
  logic              wr_en_q;

  logic [5:0]        opc;
  logic [5:0]        funct;
  logic [RegAw-1:0]  rs;
  logic [RegAw-1:0]  rt;
  logic [RegAw-1:0]  rd;
  logic [15:0]       imm;
  logic [XLen-1:0]   rs_val;
  logic [XLen-1:0]   rt_val;
  logic              trap_hit;

  logic              dec_legal;
  logic              dec_is_rtype;
  ext_kind_e         dec_ext;
  dest_sel_e         dec_dest;

  assign opc   = instr_q[OpcMsb:OpcLsb];
  assign funct = instr_q[FunctMsb:FunctLsb];
  assign rs    = instr_q[RsMsb:RsLsb];
  assign rt    = instr_q[RtMsb:RtLsb];
  assign rd    = instr_q[RdMsb:RdLsb];
  assign imm   = instr_q[ImmMsb:ImmLsb];

  // r0 reads as zero regardless of storage contents.
  assign rs_val = (rs == '0) ? '0 : regs_q[rs];
  assign rt_val = (rt == '0) ? '0 : regs_q[rt];

  assign instr_ready = (state_q == StIdle);

  alu_issue_decode u_decode (
    .opcode   (opc),
    .funct    (funct),
    .legal    (dec_legal),
    .is_rtype (dec_is_rtype),
    .ext_kind (dec_ext),
    .dest_sel (dec_dest)
  );

`ifdef ALU_ISSUE_OVF_TRAP_EN
  assign trap_hit = arith_q & alu_ovf;
`else
  assign trap_hit = 1'b0;
  assign ovf_trap = 1'b0;
  logic unused_ovf;
  assign unused_ovf = alu_ovf ^ arith_q;
`endif

  // Main FSM with registered ALU operands and writeback/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      alu_opcode <= '0;
      alu_funct  <= '0;
      dest_q     <= '0;
      legal_q    <= 1'b0;
      arith_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      zero_flag  <= 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
      ovf_trap   <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      unique case (state_q)
        StIdle: begin
          wr_en_q <= 1'b0;
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          alu_rs1    <= rs_val;
          alu_rs2    <= dec_is_rtype ? rt_val : extend_imm(dec_ext, imm);
          alu_opcode <= opc;
          alu_funct  <= dec_is_rtype ? funct : 6'b000000;
          dest_q     <= (dec_dest == DestRd) ? rd : rt;
          legal_q    <= dec_legal;
          arith_q    <= is_arith(dec_is_rtype, opc, funct);
          // Raised here so the pulse coincides with the EXEC cycle.
          illegal    <= ~dec_legal;
          state_q    <= StExec;
        end
        StExec: begin
          zero_flag <= alu_zero;
          if (legal_q) begin
            done    <= 1'b1;
            wb_addr <= dest_q;
            wb_data <= alu_result;
            wr_en_q <= ~trap_hit;
`ifdef ALU_ISSUE_OVF_TRAP_EN
            if (trap_hit) begin
              ovf_trap <= 1'b1;
            end
`endif
            state_q <= StWb;
          end else begin
            state_q <= StIdle;
          end
        end
        StWb: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Register file: committed at the end of WB so a reset during WB drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RegCnt); i++) begin
        regs_q[i] <= '0;
      end
    end else if ((state_q == StWb) && wr_en_q && (wb_addr != '0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // done and illegal are mutually exclusive by construction.
  a_done_illegal_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(done && illegal));

  // Ready is only ever seen outside the pipeline stages.
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> !instr_ready);

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/writeback controller that drives the 32-bit ALU from the instruction side. Accepts one 32-bit MIPS-format instruction per valid/ready handshake, decodes opcode/funct, reads operands from an internal 32×32 register file, presents them to the ALU, captures result/zero/ovf and writes the destination register. It sits between the fetch stage and the combinational ALU.

## Interface
- REG_CNT, 32: number of architectural registers (fixed 32; index width 5).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction word available.
- instr  in  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm16, [5:0] funct.
- instr_ready  out  1  controller can accept; high only in IDLE.
- alu_rs1  out  32  ALU operand 1 (reg[rs]).
- alu_rs2  out  32  ALU operand 2 (reg[rt] for R-type, extended imm for I-type).
- alu_opcode  out  6  opcode to the ALU.
- alu_funct  out  6  funct to the ALU (0 for I-type).
- alu_result  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_ovf  in  1  ALU overflow flag.
- done  out  1  one-cycle pulse at writeback.
- wb_addr  out  5  destination written at done.
- wb_data  out  32  value written at done.
- zero_flag  out  1  alu_zero captured at EXEC, held until the next EXEC.
- illegal  out  1  one-cycle pulse for unsupported opcode/funct.
- ovf_trap  out  1  sticky overflow trap (see Configuration).

## Operation
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE→DECODE on instr_valid && instr_ready; instr latched.
  - DECODE→EXEC always.
  - EXEC→WB for legal ops.
  - EXEC→IDLE for illegal ops, with illegal pulsed.
  - WB→IDLE always.
- Legal R-type (opcode 0), by funct:
  - 001000–001101: add/sub/inc/dec/slt/sgt.
  - 010000–010100: logic.
  - 011001, 011010, 011011: shifts.
  - 101000: ham.
  - 110000, 110001: move/cmov.
  - Destination is rd.
- Legal I-type, by opcode; destination is rt:
  - 001000, 001001: sign-extend imm16.
  - 010000–010010: zero-extend.
  - 011000–011010: zero-extend; the shift amount is imm[4:0].
  - 110000 (LUI): rs2 = {16'b0, imm16}.
- DECODE registers alu_rs1, alu_rs2, alu_opcode and alu_funct. They are held stable through EXEC.
- EXEC samples alu_result, alu_zero and alu_ovf.
- Write rules:
  - Writes to r0 are discarded. r0 always reads 0.
  - wb_addr=0 is still reported with done.
- Register file updates only in WB. Reads in DECODE see all prior writebacks.
- instr_valid outside IDLE is ignored; no buffering.

## Timing
- Handshake at cycle 0 (edge E0):
  - DECODE during cycle 1.
  - EXEC during cycle 2.
  - WB/done during cycle 3.
  - Next instr_ready in cycle 4.
  - Throughput is one instruction per 4 cycles.
- ALU path is combinational. alu_result must be valid within the EXEC cycle.
- Reset (asynchronous, any state) → IDLE with all of the following:
  - instr_ready=1 (first cycle after deassertion).
  - done=0, illegal=0, ovf_trap=0, zero_flag=0.
  - wb_addr=0, wb_data=0.
  - alu_* outputs = 0.
  - All registers = 0.
- Reset mid-instruction: the in-flight instruction is discarded and no write occurs.
- done and illegal are never high together.

## Configuration
- ALU_ISSUE_OVF_TRAP_EN defined:
  - alu_ovf=1 in EXEC for an add/sub-class op suppresses the register write.
  - done still pulses, with wb_data = alu_result.
  - ovf_trap sets and holds until reset.
- Undefined:
  - Result always written.
  - ovf_trap tied to 0.

## Structure
- Shared package alu_isa_pkg holds:
  - opcode and funct localparams;
  - field-slice positions;
  - the FSM state enum;
  - an imm-extension-kind enum (SEXT, ZEXT, LUI).
- Decode-legality and extension select form one combinational sub-module, alu_issue_decode (inputs opcode/funct; outputs legal, is_rtype, ext_kind, dest_sel). The FSM and register file stay in the top.

## Test plan
- ADDI r1,r0,-5 (0x2001FFFB), then ADD r2,r1,r1:
  - alu_rs2 = 0xFFFFFFFB for the ADDI.
  - wb r1 = 0xFFFFFFFB; wb r2 = 0xFFFFFFF6.
  - Each done pulse lands exactly 3 cycles after its handshake.
- ANDI r3,r1,0x8001 → alu_rs2 = 0x00008001; wb r3 = 0x00008001.
- LUI r4,0x1234 → alu_rs2 = 0x00001234; wb r4 = ALU result; zero_flag = 0.
- r5=0x7FFFFFFF (via LUI 0x7FFF, then ORI 0xFFFF), then ADD r6,r5,r5:
  - With macro: r6 stays 0 and ovf_trap = 1.
  - Without macro: r6 = 0xFFFFFFFE and ovf_trap = 0.
- Opcode 111111 → illegal pulses in cycle 2, no done, no register change, instr_ready back high in cycle 3.
- Additional cases:
  - ADDI r0,r0,7 → done with wb_addr 0; r0 still reads 0.
  - rst_n asserted during EXEC → all outputs at reset values immediately; target register unchanged.
